button_arbiter: RTL and testbench

BUTTON_ARBITER -- requirements
Module: button_arbiter

---
 rtl/button_arbiter_pkg.sv | 13 +
 rtl/button_arbiter_onehot_encoder.sv | 21 ++
 rtl/button_arbiter.sv | 88 ++++++++
 tb/tb_button_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/button_arbiter_pkg.sv
// button_arbiter_pkg: shared FSM state type and parameter defaults for the button arbiter
package button_arbiter_pkg;
  localparam int NUM_BTN_DEF        = 7;
  localparam int CODE_W_DEF         = 3;
  localparam int TIMEOUT_CYCLES_DEF = 10000;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARMED,
    ST_PRESENT,
    ST_RELEASE
  } state_t;
endpackage

// File: rtl/button_arbiter_onehot_encoder.sv
// onehot_encoder: maps a button vector to {lowest set index, exactly-one, none}
module onehot_encoder
  import button_arbiter_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF,
  parameter int CODE_W  = CODE_W_DEF
) (
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [CODE_W-1:0]  o_index,
  output logic               o_single,
  output logic               o_none
);
  // scan from the top so the lowest set bit wins; only meaningful when o_single
  always_comb begin
    o_index = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (i_btn[i]) o_index = CODE_W'(i);
  end
  assign o_none   = ~|i_btn;
  assign o_single = !o_none && ((i_btn & (i_btn - NUM_BTN'(1))) == '0);
endmodule

// File: rtl/button_arbiter.sv
// button_arbiter: captures exactly one debounced button press per arm request
module button_arbiter
  import button_arbiter_pkg::*;
#(
  parameter int NUM_BTN        = NUM_BTN_DEF,
  parameter int CODE_W         = CODE_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk_2k,
  input  logic               rst_n,
  input  logic               arm,
  input  logic [NUM_BTN-1:0] btn_db,
  output logic               evt_valid,
  output logic [CODE_W-1:0]  evt_code,
  input  logic               evt_ready,
  output logic               timeout,
  output logic               multi_err,
  output logic               busy
);
  localparam int              CNT_W    = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t              r_state, w_nxt_state;
  logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;
  logic [CODE_W-1:0]   r_code, w_nxt_code, w_idx;
  logic                r_timeout, w_nxt_timeout;
  logic                r_multi, w_nxt_multi;
  logic                w_single, w_none;
  onehot_encoder #(
    .NUM_BTN(NUM_BTN),
    .CODE_W (CODE_W)
  ) u_enc (
    .i_btn   (btn_db),
    .o_index (w_idx),
    .o_single(w_single),
    .o_none  (w_none)
  );
  // state, counter, latched code and the two pulse flags
  always_ff @(posedge clk_2k or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_code    <= '0;
      r_timeout <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_code    <= w_nxt_code;
      r_timeout <= w_nxt_timeout;
      r_multi   <= w_nxt_multi;
    end
  end
  // next state; in ARMED abort beats press, press beats multi and timeout
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_code    = r_code;
    w_nxt_timeout = 1'b0;
    w_nxt_multi   = 1'b0;
    case (r_state)
      ST_IDLE:    if (arm) w_nxt_state = ST_CLEAR;
      ST_CLEAR: begin
        w_nxt_cnt = '0;
        if (w_none) w_nxt_state = ST_ARMED;
      end
      ST_ARMED:
        if (!arm) w_nxt_state = ST_IDLE;
        else if (w_single) begin
          w_nxt_code  = w_idx;
          w_nxt_state = ST_PRESENT;
        end else if (!w_none) begin
          w_nxt_multi = 1'b1;
          w_nxt_state = ST_RELEASE;
        end else if (r_cnt == CNT_LAST) begin
          w_nxt_timeout = 1'b1;
          w_nxt_state   = ST_IDLE;
        end else w_nxt_cnt = r_cnt + CNT_W'(1);
      ST_PRESENT: if (evt_ready) w_nxt_state = ST_RELEASE;
      ST_RELEASE: if (w_none) w_nxt_state = ST_IDLE;
      default:    w_nxt_state = ST_IDLE;
    endcase
  end
  assign evt_valid = r_state == ST_PRESENT;
  assign busy      = r_state != ST_IDLE;
  assign evt_code  = r_code;
  assign timeout   = r_timeout;
  assign multi_err = r_multi;
endmodule

// File: tb/tb_button_arbiter.sv
// tb_button_arbiter: directed vector table plus multi-cycle sequences for button_arbiter
module tb_button_arbiter;
  logic       clk_2k = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       evt_ready = 1'b0;
  logic [6:0] btn_db = '0;
  logic       evt_valid, timeout, multi_err, busy;
  logic [2:0] evt_code;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic       a;
    logic [6:0] b;
    logic       r;
    logic       v;
    logic [2:0] c;
    logic       bz;
    logic       to;
    logic       me;
  } vec_t;
  vec_t vec [24];

  button_arbiter dut (
    .clk_2k   (clk_2k),
    .rst_n    (rst_n),
    .arm      (arm),
    .btn_db   (btn_db),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_ready(evt_ready),
    .timeout  (timeout),
    .multi_err(multi_err),
    .busy     (busy)
  );

  always #5 clk_2k = ~clk_2k;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input logic a, input logic [6:0] b, input logic r);
    arm = a;
    btn_db = b;
    evt_ready = r;
    @(posedge clk_2k);
    #1;
  endtask

  int pulses, at, bad;

  initial begin
    vec[0]  = '{1, 7'h00, 1, 0, 0, 1, 0, 0};
    vec[1]  = '{1, 7'h00, 1, 0, 0, 1, 0, 0};
    vec[2]  = '{1, 7'h04, 1, 1, 2, 1, 0, 0};
    vec[3]  = '{1, 7'h04, 1, 0, 0, 1, 0, 0};
    vec[4]  = '{0, 7'h04, 1, 0, 0, 1, 0, 0};
    vec[5]  = '{0, 7'h00, 1, 0, 0, 0, 0, 0};
    vec[6]  = '{1, 7'h00, 1, 0, 0, 1, 0, 0};
    vec[7]  = '{1, 7'h00, 1, 0, 0, 1, 0, 0};
    vec[8]  = '{1, 7'h11, 1, 0, 0, 1, 0, 1};
    vec[9]  = '{1, 7'h11, 1, 0, 0, 1, 0, 0};
    vec[10] = '{1, 7'h00, 1, 0, 0, 0, 0, 0};
    vec[11] = '{0, 7'h00, 1, 0, 0, 0, 0, 0};
    vec[12] = '{1, 7'h20, 1, 0, 0, 1, 0, 0};
    vec[13] = '{1, 7'h20, 1, 0, 0, 1, 0, 0};
    vec[14] = '{1, 7'h20, 1, 0, 0, 1, 0, 0};
    vec[15] = '{1, 7'h00, 1, 0, 0, 1, 0, 0};
    vec[16] = '{1, 7'h20, 0, 1, 5, 1, 0, 0};
    vec[17] = '{0, 7'h01, 0, 1, 5, 1, 0, 0};
    vec[18] = '{0, 7'h00, 1, 0, 0, 1, 0, 0};
    vec[19] = '{0, 7'h00, 1, 0, 0, 0, 0, 0};
    vec[20] = '{1, 7'h00, 1, 0, 0, 1, 0, 0};
    vec[21] = '{1, 7'h00, 1, 0, 0, 1, 0, 0};
    vec[22] = '{0, 7'h00, 1, 0, 0, 0, 0, 0};
    vec[23] = '{0, 7'h02, 1, 0, 0, 0, 0, 0};

    #12;
    chk("reset valid", evt_valid, 0);
    chk("reset code", evt_code, 0);
    chk("reset busy", busy, 0);
    chk("reset timeout", timeout, 0);
    chk("reset multi", multi_err, 0);
    rst_n = 1'b1;
    @(posedge clk_2k);
    #1;
    chk("idle after reset busy", busy, 0);

    for (int i = 0; i < 24; i++) begin
      step(vec[i].a, vec[i].b, vec[i].r);
      chk($sformatf("vec%0d valid", i), evt_valid, vec[i].v);
      if (vec[i].v) chk($sformatf("vec%0d code", i), evt_code, vec[i].c);
      chk($sformatf("vec%0d busy", i), busy, vec[i].bz);
      chk($sformatf("vec%0d timeout", i), timeout, vec[i].to);
      chk($sformatf("vec%0d multi", i), multi_err, vec[i].me);
    end

    // timeout after exactly 10000 idle cycles in ARMED
    step(1, 0, 1);
    step(1, 0, 1);
    pulses = 0;
    at = 0;
    for (int k = 1; k <= 10000; k++) begin
      step(1, 0, 1);
      if (timeout) begin
        pulses++;
        at = k;
      end
    end
    chk("timeout pulse count", pulses, 1);
    chk("timeout pulse cycle", at, 10000);
    chk("timeout busy", busy, 0);
    step(0, 0, 1);
    chk("timeout one cycle", timeout, 0);

    // press on the final counter cycle beats the timeout
    step(1, 0, 1);
    step(1, 0, 1);
    pulses = 0;
    for (int k = 1; k < 10000; k++) begin
      step(1, 0, 1);
      if (timeout) pulses++;
    end
    chk("early timeout pulses", pulses, 0);
    step(1, 7'h02, 0);
    chk("press wins timeout", timeout, 0);
    chk("press wins valid", evt_valid, 1);
    chk("press wins code", evt_code, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("press wins idle", busy, 0);

    // PRESENT holds for 50 cycles with ready low and buttons moving
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 7'h08, 0);
    chk("hold entry code", evt_code, 3);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(0, 7'(i * 13 + 1), 0);
      if (!evt_valid || evt_code != 3'd3) bad++;
    end
    chk("hold stable cycles bad", bad, 0);
    step(0, 7'h7f, 1);
    chk("hold release valid", evt_valid, 0);
    chk("hold release busy", busy, 1);
    step(0, 0, 0);
    chk("hold idle busy", busy, 0);

    // asynchronous reset while presenting
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 7'h40, 0);
    chk("pre-reset code", evt_code, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid", evt_valid, 0);
    chk("async reset code", evt_code, 0);
    chk("async reset busy", busy, 0);
    chk("async reset pulses", {timeout, multi_err}, 0);
    #3 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 7'h40, 1);
      if (evt_valid || busy) bad++;
    end
    chk("no capture without arm", bad, 0);
    step(0, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 7'h01, 0);
    chk("rearm valid", evt_valid, 1);
    chk("rearm code", evt_code, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
